alpha_scroll_scan: RTL
======================

// Module: alpha_scroll_scan
// PURPOSE
//  Upstream feeder for the 5-bit-code 14-segment alphanumeric decoder. Stores a message of 5-bit
//  character codes, scrolls it across NUM_DIGITS multiplexed positions and time-scans the digits.
//  Each cycle it presents one digit's code (code[4]=a .. code[0]=e to the decoder) plus a one-hot digit enable.
// PARAMETERS
//  NUM_DIGITS    4     physical digit positions; digit 0 = leftmost
//  MSG_DEPTH     16    max message length, chars (power of 2 not required; >= 1)
//  SCAN_DIV      1000  clocks each digit slot is held
//  SCROLL_FRAMES 250   full scan frames (NUM_DIGITS slots) per scroll step
// PORTS
//  clk       in   1            single clock, rising edge
//  rst       in   1            synchronous, active-high reset
//  clear     in   1            abort message, return to IDLE
//  wr_valid  in   1            char write request
//  wr_ready  out  1            char can be accepted this cycle
//  wr_code   in   5            character code
//  wr_last   in   1            final char of message (commits message)
//  code      out  5            code of currently scanned digit, to decoder a..e
//  digit_en  out  NUM_DIGITS   one-hot active-high digit select; all-zero = dark
//  busy      out  1            high in RUN
// BEHAVIOUR
//  - Reset: state IDLE, len=0, pos=0, all counters 0, code=0, digit_en=0, busy=0, wr_ready=1.
//  - Transfer occurs when wr_valid && wr_ready at a rising edge.
//  - wr_ready = (state!=RUN) && !clear && (len<MSG_DEPTH), combinational.
//  - States: IDLE: len=0, display dark; a transfer stores buf[0], len=1, goes to LOAD (or RUN if wr_last).
//    LOAD: each transfer stores buf[len], len++; transfer with wr_last, or the MSG_DEPTH-th char, -> RUN.
//    RUN: scanning; writes refused. clear in any state -> IDLE, len=0, pos=0, counters 0.
//  - clear wins over a same-cycle write (write dropped; wr_ready low).
//  - On RUN entry: scan_cnt=0, slot=0, frame_cnt=0, pos=0.
//  - Scan: scan_cnt counts 0..SCAN_DIV-1; on terminal count slot advances, slot NUM_DIGITS-1 wraps to 0
//    and ends a frame. frame_cnt counts 0..SCROLL_FRAMES-1; on terminal count at a frame end, pos advances.
//  - Scroll: only if len>NUM_DIGITS; pos = (pos+1) mod len (wraps to 0 after len-1).
//    If len<=NUM_DIGITS, pos stays 0.
//  - Digit i shows buf[(pos+i) mod len] when len>NUM_DIGITS.
//    Otherwise it shows buf[i] for i<len and is dark for i>=len (digit_en=0, code=0).
//  - code and digit_en are registered and change in the same cycle.
//    Latency: they reflect (state, slot, pos) of the previous cycle. First lit slot: 1 cycle after RUN entry.
//  - IDLE/LOAD: digit_en=0, code=0, busy=0. RUN: busy=1.
//  - Reset or clear mid-scan: outputs dark on the next cycle; buffer contents are don't-care.
//  - Arithmetic: pos/index widths = clog2(MSG_DEPTH); modulo done by compare-subtract, no divider.
// CONFIGURATION
//  ALPHA_SCAN_GHOST_BLANK_EN defined: digit_en forced to 0 during the first clock of every digit slot
//    (scan_cnt==0), giving an anti-ghosting dead time. code still updates on schedule.
//    Requires SCAN_DIV>=2.
//  Not defined: digit_en is held for all SCAN_DIV clocks of the slot.
// TESTING (bench params NUM_DIGITS=4, MSG_DEPTH=8, SCAN_DIV=4, SCROLL_FRAMES=2)
//  1. Reset -> code=0, digit_en=0, busy=0, wr_ready=1 while rst high and 1 cycle after.
//  2. Write codes 1,2,3 with wr_last on 3 -> busy rises.
//     digit_en cycles 0001,0010,0100,0000 every 4 clocks; codes 1,2,3,x. pos never moves.
//  3. Write codes 1..6 (last=6) -> frames 0-1 show 1,2,3,4; frames 2-3 show 2,3,4,5.
//     After pos=5, digits show 6,1,2,3 (wrap).
//  4. Write 8 codes without wr_last -> commit on 8th char; wr_ready=0 from then on.
//     A 9th wr_valid is never accepted.
//  5. clear asserted in RUN mid-slot together with wr_valid -> next cycle digit_en=0, busy=0.
//     No char stored; the following write becomes buf[0].
//  6. Apply rst mid-LOAD, then reload codes 9,10 -> only 9,10 displayed.
//     With ALPHA_SCAN_GHOST_BLANK_EN, digit_en=0 on each slot's first clock.

Source files
------------

// File: rtl/alpha_scroll_scan_if.sv
// Character-write handshake and scan outputs of the alpha_scroll_scan feeder.
// Handshake: a char transfers on a rising edge where wr_valid && wr_ready; wr_valid may not depend on wr_ready.
interface alpha_scroll_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  clear;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [4:0]            wr_code;
  logic                  wr_last;
  logic [4:0]            code;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  busy;

  modport master (
    output clear, wr_valid, wr_code, wr_last,
    input  wr_ready, code, digit_en, busy
  );

  modport slave (
    input  clear, wr_valid, wr_code, wr_last,
    output wr_ready, code, digit_en, busy
  );
endinterface

// File: rtl/alpha_scroll_scan.sv
// Message buffer + scroll + digit time-scan feeding a 5-bit-code 14-segment decoder.
// Optional `ALPHA_SCAN_GHOST_BLANK_EN: blank digit_en on the first clock of every digit slot.
module alpha_scroll_scan #(
  parameter int NUM_DIGITS    = 4,
  parameter int MSG_DEPTH     = 16,
  parameter int SCAN_DIV      = 1000,
  parameter int SCROLL_FRAMES = 250
) (
  input  logic               clk,
  input  logic               rst,
  alpha_scroll_scan_if.slave bus,
  output logic [1:0]         dbg_state_o
);
  localparam int IW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [IW-1:0]         pos_q, pos_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [DW-1:0]         slot_q, slot_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [4:0]            code_q, code_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [4:0]            buf_q [MSG_DEPTH];

  logic          wr_fire, wr_en;
  logic [IW-1:0] wr_addr, rd_idx;
  logic [IW:0]   sum;
  logic          lit;

  assign bus.wr_ready = (state_q != S_RUN) && !bus.clear && (int'(len_q) < MSG_DEPTH);
  assign wr_fire      = bus.wr_valid && bus.wr_ready;
  assign bus.busy     = (state_q == S_RUN);
  assign bus.code     = code_q;
  assign bus.digit_en = en_q;
  assign dbg_state_o  = state_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pos_d   = pos_q;
    scan_d  = scan_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    wr_en   = 1'b0;
    wr_addr = IW'(len_q);
    if (bus.clear) begin
      state_d = S_IDLE;
      len_d   = '0;
      pos_d   = '0;
      scan_d  = '0;
      slot_d  = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD: begin
          // IDLE always has len 0, so the first char lands in buf[0] through the same path
          if (wr_fire) begin
            wr_en = 1'b1;
            len_d = len_q + 1'b1;
            if (bus.wr_last || (int'(len_q) + 1 == MSG_DEPTH)) begin
              state_d = S_RUN;
              pos_d   = '0;
              scan_d  = '0;
              slot_d  = '0;
              frame_d = '0;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_RUN: begin
          if (int'(scan_q) == SCAN_DIV - 1) begin
            scan_d = '0;
            if (int'(slot_q) == NUM_DIGITS - 1) begin
              slot_d = '0;
              if (int'(frame_q) == SCROLL_FRAMES - 1) begin
                frame_d = '0;
                if (int'(len_q) > NUM_DIGITS)
                  pos_d = (int'(pos_q) == int'(len_q) - 1) ? '0 : pos_q + 1'b1;
              end else begin
                frame_d = frame_q + 1'b1;
              end
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end else begin
            scan_d = scan_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Display index: (pos + slot) mod len by a single compare-subtract, since both terms are below len.
  always_comb begin
    en_d   = '0;
    code_d = '0;
    lit    = 1'b0;
    sum    = (IW+1)'(pos_q) + (IW+1)'(slot_q);
    if (int'(sum) >= int'(len_q)) sum = sum - (IW+1)'(len_q);
    rd_idx = sum[IW-1:0];
    if ((state_q == S_RUN) && !bus.clear) begin
      if (int'(len_q) > NUM_DIGITS) begin
        lit = 1'b1;
      end else if (int'(slot_q) < int'(len_q)) begin
        lit    = 1'b1;
        rd_idx = IW'(slot_q);
      end
      if (lit) begin
        en_d   = NUM_DIGITS'(1) << slot_q;
        code_d = buf_q[rd_idx];
      end
`ifdef ALPHA_SCAN_GHOST_BLANK_EN
      if (scan_q == '0) en_d = '0;
`else
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pos_q   <= '0;
      scan_q  <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      code_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      scan_q  <= scan_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      code_q  <= code_d;
      en_q    <= en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_addr] <= bus.wr_code;
  end
endmodule
